// File: rtl/mc6809_bus_target_if.sv
// CPU-side bus strobes plus the req/ack link to the backing memory, as seen by
// the 6809 bus target. The slave modport is the target; master is its environment.
interface mc6809_bus_target_if #(
  parameter int SIZE_LOG2 = 15
);
  logic                 riseQ;
  logic                 riseE;
  logic                 fallE;
  logic                 BA;
  logic [15:0]          ADDR;
  logic                 RnW;
  logic [7:0]           Din;
  logic [7:0]           Dout;
  logic                 SEL;
  logic                 MRDY;
  logic                 mem_req;
  logic                 mem_we;
  logic [SIZE_LOG2-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rdata;
  logic                 mem_ack;
  logic                 timeout_err;

  modport slave (
    input  riseQ, riseE, fallE, BA, ADDR, RnW, Din, mem_rdata, mem_ack,
    output Dout, SEL, MRDY, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport master (
    output riseQ, riseE, fallE, BA, ADDR, RnW, Din, mem_rdata, mem_ack,
    input  Dout, SEL, MRDY, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/mc6809_bus_target.sv
// Decodes 6809 bus cycles in an address window and bridges them to a slow memory
// over req/ack, stretching the CPU cycle via MRDY and recovering from a hung memory.
module mc6809_bus_target #(
  parameter logic [15:0] BASE      = 16'h0000,
  parameter int          SIZE_LOG2 = 15,
  parameter int          TIMEOUT   = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  mc6809_bus_target_if.slave bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RD_REQ, WR_WAIT, WR_REQ, HOLD} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mem_we_q, mem_we_d;
  logic [SIZE_LOG2-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic [7:0]           dout_q, dout_d;
  logic                 terr_q, terr_d;
  logic                 sel;
  logic                 in_req;
  logic                 rd_start;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Shifting both sides handles SIZE_LOG2 == 16, where the whole map is the window.
  assign sel      = ((bus.ADDR >> SIZE_LOG2) == (BASE >> SIZE_LOG2)) && !bus.BA;
  assign in_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign rd_start = bus.riseQ && sel && bus.RnW;

  assign bus.SEL         = sel;
  assign bus.MRDY        = !(rd_start || (bus.riseE && (state_q == WR_WAIT)) || in_req);
  assign bus.mem_req     = in_req;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.Dout        = dout_q;
  assign bus.timeout_err = terr_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dout_d      = dout_q;
    terr_d      = terr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.riseQ && sel) begin
          mem_addr_d = bus.ADDR[SIZE_LOG2-1:0];
          cnt_d      = '0;
          if (bus.RnW) begin
            mem_we_d = 1'b0;
            state_d  = RD_REQ;
          end else begin
            state_d  = WR_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (bus.riseE) begin
          mem_wdata_d = bus.Din;
          mem_we_d    = 1'b1;
          cnt_d       = '0;
          state_d     = WR_REQ;
        end
      end
      RD_REQ, WR_REQ: begin
        // An ack landing on the last allowed cycle still counts as a good completion.
        if (bus.mem_ack) begin
          state_d = HOLD;
          if (state_q == RD_REQ) dout_d = bus.mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
          terr_d  = 1'b1;
          if (state_q == RD_REQ) dout_d = 8'hFF;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      HOLD: begin
        if (bus.fallE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      dout_q      <= 8'hFF;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dout_q      <= dout_d;
      terr_q      <= terr_d;
    end
  end

endmodule

// File: tb/tb_mc6809_bus_target.sv
// Directed bench for mc6809_bus_target: a small E/Q phase sequencer honouring MRDY
// drives two targets (TIMEOUT 12 and 4) against a delayed-ack memory responder.
`timescale 1ns/1ps
module tb_mc6809_bus_target;

  localparam int CLKEN = 2;
  localparam int CYC_BOUND = 300;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mc6809_bus_target_if #(.SIZE_LOG2(15)) bus ();
  mc6809_bus_target_if #(.SIZE_LOG2(15)) bus_t ();

  assign bus_t.riseQ     = bus.riseQ;
  assign bus_t.riseE     = bus.riseE;
  assign bus_t.fallE     = bus.fallE;
  assign bus_t.BA        = bus.BA;
  assign bus_t.ADDR      = bus.ADDR;
  assign bus_t.RnW       = bus.RnW;
  assign bus_t.Din       = bus.Din;
  assign bus_t.mem_rdata = bus.mem_rdata;
  assign bus_t.mem_ack   = bus.mem_ack;

  mc6809_bus_target #(.BASE(16'h0000), .SIZE_LOG2(15), .TIMEOUT(12)) u_dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  mc6809_bus_target #(.BASE(16'h0000), .SIZE_LOG2(15), .TIMEOUT(4)) u_to (
    .CLK(CLK), .RESET(RESET), .bus(bus_t)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic       ack_en = 1'b1;
  int         ack_lat = 1;
  logic [7:0] ack_data = 8'h00;

  int          obs_req, obs_req_t, obs_low;
  logic        obs_sel, obs_unstable, obs_we;
  logic [14:0] obs_addr;
  logic [7:0]  obs_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks ack_lat cycles after seeing mem_req, even if the request vanished.
  initial begin
    logic pend;
    int   age;
    pend = 1'b0;
    age  = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge CLK); #1;
      bus.mem_ack = 1'b0;
      if (!pend && bus.mem_req && ack_en) begin
        pend = 1'b1;
        age  = 0;
      end
      if (pend) begin
        age++;
        if (age == ack_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = ack_data;
          pend          = 1'b0;
        end
      end
    end
  end

  // One CPU bus cycle: four phases of CLKEN clocks each, frozen whenever MRDY is low.
  task automatic cpu_access(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                            output logic [7:0] rdv, output int cycles);
    int   ph;
    logic fresh;
    logic adv;
    ph = 0; fresh = 1'b1; cycles = 0; rdv = 8'h00;
    obs_req = 0; obs_req_t = 0; obs_low = 0; obs_sel = 1'b0; obs_unstable = 1'b0;
    obs_we = 1'b0; obs_addr = '0; obs_wdata = 8'h00;
    bus.ADDR = a; bus.RnW = rnw; bus.Din = d;
    while (ph < 4*CLKEN && cycles < CYC_BOUND) begin
      bus.riseQ = fresh && (ph == 0);
      bus.riseE = fresh && (ph == CLKEN);
      bus.fallE = fresh && (ph == 3*CLKEN);
      @(negedge CLK);
      if (bus.riseQ) obs_sel = bus.SEL;
      if (bus.fallE) rdv = bus.Dout;
      if (!bus.MRDY) obs_low++;
      if (bus_t.mem_req) obs_req_t++;
      if (bus.mem_req) begin
        if (obs_req == 0) begin
          obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata; obs_we = bus.mem_we;
        end else if (bus.mem_addr !== obs_addr || bus.mem_wdata !== obs_wdata ||
                     bus.mem_we !== obs_we) begin
          obs_unstable = 1'b1;
        end
        obs_req++;
      end
      adv = bus.MRDY;
      @(posedge CLK); #1;
      cycles++;
      fresh = adv;
      if (adv) ph++;
    end
    bus.riseQ = 1'b0; bus.riseE = 1'b0; bus.fallE = 1'b0;
    check("bus_cycle_completed", 32'(ph), 32'(4*CLKEN));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rdv;
    int          cyc;
    int          acks_seen;
    int          lat;
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  d;

    RESET = 1'b1;
    bus.riseQ = 1'b0; bus.riseE = 1'b0; bus.fallE = 1'b0; bus.BA = 1'b0;
    bus.ADDR = 16'h0000; bus.RnW = 1'b1; bus.Din = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_mrdy",      bus.MRDY, 1'b1);
    check("rst_mem_req",   bus.mem_req, 1'b0);
    check("rst_mem_we",    bus.mem_we, 1'b0);
    check("rst_mem_addr",  bus.mem_addr, 15'h0000);
    check("rst_mem_wdata", bus.mem_wdata, 8'h00);
    check("rst_dout",      bus.Dout, 8'hFF);
    check("rst_terr",      bus.timeout_err, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Read hit, ack in the third request cycle
    ack_en = 1'b1; ack_lat = 3; ack_data = 8'h5A;
    cpu_access(16'h1234, 1'b1, 8'h00, rdv, cyc);
    check("rd_sel",      obs_sel, 1'b1);
    check("rd_mem_addr", obs_addr, 15'h1234);
    check("rd_mem_we",   obs_we, 1'b0);
    check("rd_mrdy_low", obs_low, 4);
    check("rd_req_len",  obs_req, 3);
    check("rd_dout",     rdv, 8'h5A);
    check("rd_cycles",   cyc, 4*CLKEN + 4);

    // Write hit at top of window, ack in the first request cycle
    ack_lat = 1; ack_data = 8'hEE;
    cpu_access(16'h7FFF, 1'b0, 8'hC3, rdv, cyc);
    check("wr_mem_addr",  obs_addr, 15'h7FFF);
    check("wr_mem_we",    obs_we, 1'b1);
    check("wr_mem_wdata", obs_wdata, 8'hC3);
    check("wr_mrdy_low",  obs_low, 2);
    check("wr_stable",    obs_unstable, 1'b0);
    check("wr_dout_keep", bus.Dout, 8'h5A);

    // Miss just above the window
    cpu_access(16'h8000, 1'b1, 8'h00, rdv, cyc);
    check("miss_sel",      obs_sel, 1'b0);
    check("miss_req",      obs_req, 0);
    check("miss_mrdy_low", obs_low, 0);
    check("miss_dout",     rdv, 8'h5A);
    check("miss_cycles",   cyc, 4*CLKEN);

    // In-window address while the bus is granted away
    bus.BA = 1'b1;
    cpu_access(16'h1234, 1'b1, 8'h00, rdv, cyc);
    bus.BA = 1'b0;
    check("ba_sel",      obs_sel, 1'b0);
    check("ba_req",      obs_req, 0);
    check("ba_mrdy_low", obs_low, 0);
    check("ba_dout",     bus.Dout, 8'h5A);

    // Ack on the very cycle the 4-cycle target would time out
    ack_lat = 4; ack_data = 8'hA5;
    cpu_access(16'h0ABC, 1'b1, 8'h00, rdv, cyc);
    check("race_dout",     rdv, 8'hA5);
    check("race_to_dout",  bus_t.Dout, 8'hA5);
    check("race_to_req",   obs_req_t, 4);
    check("race_to_terr",  bus_t.timeout_err, 1'b0);
    check("race_dut_terr", bus.timeout_err, 1'b0);

    // Reset during a read request, with the memory answering afterwards
    ack_lat = 4; ack_data = 8'h77;
    bus.ADDR = 16'h0100; bus.RnW = 1'b1; bus.riseQ = 1'b1;
    @(posedge CLK); #1;
    bus.riseQ = 1'b0;
    @(negedge CLK);
    check("rstmid_req_before", bus.mem_req, 1'b1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rstmid_mrdy", bus.MRDY, 1'b1);
    check("rstmid_req",  bus.mem_req, 1'b0);
    check("rstmid_dout", bus.Dout, 8'hFF);
    acks_seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (bus.mem_ack) acks_seen++;
    end
    check("rstmid_late_ack_sent", acks_seen, 1);
    check("rstmid_dout_after",    bus.Dout, 8'hFF);
    check("rstmid_req_after",     bus.mem_req, 1'b0);
    check("rstmid_mrdy_after",    bus.MRDY, 1'b1);
    @(posedge CLK); #1;
    ack_lat = 1; ack_data = 8'h99;
    cpu_access(16'h0200, 1'b1, 8'h00, rdv, cyc);
    check("rstmid_next_read", rdv, 8'h99);

    // Memory never answers
    ack_en = 1'b0;
    cpu_access(16'h0042, 1'b1, 8'h00, rdv, cyc);
    check("to_req_len",    obs_req, 12);
    check("to_t_req_len",  obs_req_t, 4);
    check("to_dout",       rdv, 8'hFF);
    check("to_t_dout",     bus_t.Dout, 8'hFF);
    check("to_terr",       bus.timeout_err, 1'b1);
    check("to_t_terr",     bus_t.timeout_err, 1'b1);
    check("to_cycles",     cyc, 4*CLKEN + 13);

    // Good access afterwards leaves the sticky flag set
    ack_en = 1'b1; ack_lat = 2; ack_data = 8'h3C;
    cpu_access(16'h0010, 1'b1, 8'h00, rdv, cyc);
    check("post_to_dout",   rdv, 8'h3C);
    check("post_to_terr",   bus.timeout_err, 1'b1);
    check("post_to_t_terr", bus_t.timeout_err, 1'b1);

    // Back-to-back accesses with random ack latency
    for (int i = 0; i < 10; i++) begin
      lat = int'($urandom_range(1, 10));
      a   = {1'b0, 15'($urandom)};
      rnw = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      ack_lat  = lat;
      ack_data = 8'($urandom);
      cpu_access(a, rnw, d, rdv, cyc);
      check($sformatf("loop%0d_cycles", i), cyc, 4*CLKEN + lat + 1);
      check($sformatf("loop%0d_addr", i), obs_addr, a[14:0]);
      check($sformatf("loop%0d_we", i), obs_we, !rnw);
      if (rnw) check($sformatf("loop%0d_rdata", i), rdv, ack_data);
      else     check($sformatf("loop%0d_wdata", i), obs_wdata, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
